// File: rtl/kernel_arb.sv
// kernel_arb
//   Shares one butterfly kernel among four stage requesters. Load beats are
//   granted round-robin (one per cycle) into a one-entry output register that
//   feeds the kernel ld_* port. The owner of every in-flight beat is kept in a
//   tag FIFO so the in-order kernel results (sw_*) are steered back to the
//   requester that issued them.
//
//   Optional build macro: KARB_PRIO0_EN
//     defined   -> requester 0 has strict priority; rr_ptr rotates among 1..3
//     undefined -> plain 4-way round robin
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_vld/rdy   per-requester load handshake (rdy is one-hot or zero)
//   req_dat       4 packed load beats, slice i = requester i
//   rsp_vld/rdy   per-requester result handshake (vld is one-hot or zero)
//   rsp_dat       4 packed result slices, each carries sw_dat
//   ld_vld/rdy/dat  registered beat to the kernel
//   sw_vld/rdy/dat  kernel result
//   busy          output register valid or tag FIFO non-empty
//   err_orphan    sticky: a result arrived while the tag FIFO was empty
module kernel_arb #(
  parameter int pIOPS_WIDTH = 128,
  parameter int pTAG_DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               req_vld,
  output logic [3:0]               req_rdy,
  input  logic [4*pIOPS_WIDTH-1:0] req_dat,
  output logic [3:0]               rsp_vld,
  input  logic [3:0]               rsp_rdy,
  output logic [4*pIOPS_WIDTH-1:0] rsp_dat,
  output logic                     ld_vld,
  input  logic                     ld_rdy,
  output logic [pIOPS_WIDTH-1:0]   ld_dat,
  input  logic                     sw_vld,
  output logic                     sw_rdy,
  input  logic [pIOPS_WIDTH-1:0]   sw_dat,
  output logic                     busy,
  output logic                     err_orphan
);

  localparam int PW = (pTAG_DEPTH > 1) ? $clog2(pTAG_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(pTAG_DEPTH);

  logic [1:0]    rr_ptr;
  logic [1:0]    tag_mem [pTAG_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] tag_cnt;

  logic [1:0] head_tag;
  logic [1:0] gnt_idx;
  logic [1:0] cand;
  logic       gnt_found;
  logic       fifo_empty;
  logic       out_free;
  logic       can_grant;
  logic       gnt;
  logic       pop;

  assign fifo_empty = (tag_cnt == '0);
  assign head_tag   = tag_mem[rd_ptr];
  assign out_free   = !ld_vld || ld_rdy;
  // Registered count only: a pop in this cycle does not open a slot until next cycle.
  assign can_grant  = !rst && out_free && (tag_cnt < DEPTH_C);
  assign gnt        = can_grant && gnt_found;
  assign req_rdy    = gnt ? (4'b0001 << gnt_idx) : 4'b0000;

  // Winner search starting at rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 2'd0;
`ifdef KARB_PRIO0_EN
    if (req_vld[0]) begin
      gnt_found = 1'b1;
      gnt_idx   = 2'd0;
    end
`endif
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
`ifdef KARB_PRIO0_EN
      if (!gnt_found && cand != 2'd0 && req_vld[cand]) begin
`else
      if (!gnt_found && req_vld[cand]) begin
`endif
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Results are steered to the head-of-FIFO owner; with no owner they are dropped.
  always_comb begin
    rsp_vld = 4'b0000;
    sw_rdy  = 1'b1;
    if (!fifo_empty) begin
      rsp_vld[head_tag] = sw_vld;
      sw_rdy            = rsp_rdy[head_tag];
    end
  end

  assign pop     = sw_vld && sw_rdy && !fifo_empty;
  assign rsp_dat = {4{sw_dat}};
  assign busy    = ld_vld || !fifo_empty;

  always_ff @(posedge clk) begin
    if (gnt) tag_mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_vld     <= 1'b0;
      ld_dat     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_cnt    <= '0;
      rr_ptr     <= 2'd0;
      err_orphan <= 1'b0;
    end else begin
      if (gnt) begin
        ld_vld <= 1'b1;
        ld_dat <= req_dat[gnt_idx*pIOPS_WIDTH +: pIOPS_WIDTH];
      end else if (ld_rdy) begin
        ld_vld <= 1'b0;
      end

      if (gnt) begin
        wr_ptr <= wr_ptr + PW'(1);
`ifdef KARB_PRIO0_EN
        if (gnt_idx != 2'd0) rr_ptr <= (gnt_idx == 2'd3) ? 2'd1 : gnt_idx + 2'd1;
`else
        rr_ptr <= gnt_idx + 2'd1;
`endif
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case ({gnt, pop})
        2'b10:   tag_cnt <= tag_cnt + CW'(1);
        2'b01:   tag_cnt <= tag_cnt - CW'(1);
        default: tag_cnt <= tag_cnt;
      endcase

      if (sw_vld && fifo_empty) err_orphan <= 1'b1;
    end
  end

endmodule
